// File: rtl/ibex_hpm_counter_ctrl.sv
// HPM counter control: event select/inhibit, CSR write strobes, overflow/irq/freeze.
// Define IBEX_HPM_EVENT_PIPE_EN to register event_i before selection.
module ibex_hpm_counter_ctrl #(
    parameter int unsigned NumEvents    = 16,
    parameter int unsigned CounterWidth = 40
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumEvents-1:0] event_i,
    input  logic                 csr_we_i,
    input  logic                 csr_sel_lo_i,
    input  logic                 csr_sel_hi_i,
    input  logic                 csr_sel_evt_i,
    input  logic                 csr_sel_ctrl_i,
    input  logic [31:0]          csr_wdata_i,
    input  logic [63:0]          counter_val_i,
    output logic                 counter_inc_o,
    output logic                 counter_we_o,
    output logic                 counterh_we_o,
    output logic [31:0]          counter_wdata_o,
    output logic [NumEvents-1:0] evt_sel_o,
    output logic [3:0]           ctrl_o,
    output logic                 ovf_irq_o
);

    localparam logic HasHi = (CounterWidth > 32);

    logic [NumEvents-1:0] evt_sel_q;
    logic [NumEvents-1:0] event_p;
    logic                 inhibit_q;
    logic                 ovf_q;
    logic                 irq_en_q;
    logic                 freeze_en_q;
    logic                 irq_q;
    logic                 hit;
    logic                 wr_any;
    logic                 wrap;
    logic                 ctrl_we;
    logic                 evt_we;
    logic                 unused;

`ifdef IBEX_HPM_EVENT_PIPE_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            event_p <= '0;
        end else begin
            event_p <= event_i;
        end
    end
`else
    assign event_p = event_i;
`endif

    assign hit     = |(event_p & evt_sel_q);
    assign wr_any  = csr_we_i & (csr_sel_lo_i | csr_sel_hi_i);
    assign ctrl_we = csr_we_i & csr_sel_ctrl_i;
    assign evt_we  = csr_we_i & csr_sel_evt_i;

    // Strobes are forced low while reset is held, even if the CSR side is active.
    assign counter_inc_o   = rst_ni & hit & ~inhibit_q & ~wr_any;
    assign counter_we_o    = rst_ni & csr_we_i & csr_sel_lo_i;
    assign counterh_we_o   = rst_ni & csr_we_i & csr_sel_hi_i & HasHi;
    assign counter_wdata_o = csr_wdata_i;

    assign wrap = counter_inc_o &
                  (counter_val_i[CounterWidth-1:0] == {CounterWidth{1'b1}});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            evt_sel_q   <= '0;
            inhibit_q   <= 1'b0;
            ovf_q       <= 1'b0;
            irq_en_q    <= 1'b0;
            freeze_en_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (evt_we) begin
                evt_sel_q <= csr_wdata_i[NumEvents-1:0];
            end
            // A wrap in the same cycle as a W1C keeps the flag set.
            if (wrap) begin
                ovf_q <= 1'b1;
            end else if (ctrl_we && csr_wdata_i[1]) begin
                ovf_q <= 1'b0;
            end
            if (ctrl_we) begin
                inhibit_q   <= csr_wdata_i[0];
                irq_en_q    <= csr_wdata_i[2];
                freeze_en_q <= csr_wdata_i[3];
            end else if (wrap && freeze_en_q) begin
                inhibit_q <= 1'b1;
            end
            irq_q <= ovf_q & irq_en_q;
        end
    end

    assign evt_sel_o = evt_sel_q;
    assign ctrl_o    = {freeze_en_q, irq_en_q, ovf_q, inhibit_q};
    assign ovf_irq_o = irq_q;

    assign unused = ^{counter_val_i, csr_wdata_i};

endmodule

// File: tb/tb_ibex_hpm_counter_ctrl.sv
// Scoreboard bench for ibex_hpm_counter_ctrl against a behavioural model.
// Honours IBEX_HPM_EVENT_PIPE_EN the same way as the design build.
module tb_ibex_hpm_counter_ctrl;

    localparam int NE = 16;
    localparam int CW = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NE-1:0] ev = '0;
    logic          we = 1'b0;
    logic          lo = 1'b0;
    logic          hi = 1'b0;
    logic          se = 1'b0;
    logic          sc = 1'b0;
    logic [31:0]   wd = '0;
    logic [63:0]   cv = '0;

    logic          inc, cwe, cwe_h;
    logic [31:0]   cwd;
    logic [NE-1:0] sel;
    logic [3:0]    ctrl;
    logic          irq;

    logic          inc32, cwe32, cwe_h32, irq32;
    logic [31:0]   cwd32;
    logic [NE-1:0] sel32;
    logic [3:0]    ctrl32;

    always #5 clk = ~clk;

    ibex_hpm_counter_ctrl #(.NumEvents(NE), .CounterWidth(CW)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .event_i(ev),
        .csr_we_i(we), .csr_sel_lo_i(lo), .csr_sel_hi_i(hi),
        .csr_sel_evt_i(se), .csr_sel_ctrl_i(sc), .csr_wdata_i(wd),
        .counter_val_i(cv),
        .counter_inc_o(inc), .counter_we_o(cwe), .counterh_we_o(cwe_h),
        .counter_wdata_o(cwd), .evt_sel_o(sel), .ctrl_o(ctrl),
        .ovf_irq_o(irq)
    );

    ibex_hpm_counter_ctrl #(.NumEvents(NE), .CounterWidth(32)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n), .event_i(ev),
        .csr_we_i(we), .csr_sel_lo_i(lo), .csr_sel_hi_i(hi),
        .csr_sel_evt_i(se), .csr_sel_ctrl_i(sc), .csr_wdata_i(wd),
        .counter_val_i(cv),
        .counter_inc_o(inc32), .counter_we_o(cwe32), .counterh_we_o(cwe_h32),
        .counter_wdata_o(cwd32), .evt_sel_o(sel32), .ctrl_o(ctrl32),
        .ovf_irq_o(irq32)
    );

    typedef struct {
        logic          inc;
        logic          we;
        logic          weh;
        logic [31:0]   wd;
        logic [NE-1:0] sel;
        logic [3:0]    ctrl;
        logic          irq;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   inc_seen = 0;

    // Reference state
    int unsigned m_sel;
    bit          m_inh, m_ovf, m_irqen, m_frz, m_irq;
    int unsigned m_prev_ev;

    function automatic void model_reset();
        m_sel = 0; m_inh = 0; m_ovf = 0; m_irqen = 0;
        m_frz = 0; m_irq = 0; m_prev_ev = 0;
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] b);
        checks++;
        if (a !== b) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", n, a, b, $time);
        end
    endtask

    task automatic step(input logic [NE-1:0] e, input bit w, input bit l,
                        input bit h, input bit s_e, input bit s_c,
                        input logic [31:0] d, input logic [63:0] c);
        exp_t        x;
        int unsigned evp;
        bit          hitm, wrap, ctrlw;
        longint unsigned mask;
        @(negedge clk);
        ev = e; we = w; lo = l; hi = h; se = s_e; sc = s_c; wd = d; cv = c;
`ifdef IBEX_HPM_EVENT_PIPE_EN
        evp = m_prev_ev;
`else
        evp = int'(e);
`endif
        m_prev_ev = int'(e);
        hitm  = (evp & m_sel) != 0;
        x.inc = hitm && !m_inh && !(w && (l || h));
        x.we  = w && l;
        x.weh = w && h;
        x.wd  = d;
        x.sel = m_sel[NE-1:0];
        x.ctrl = {m_frz, m_irqen, m_ovf, m_inh};
        x.irq = m_irq;
        q.push_back(x);
        mask = (64'd1 << CW) - 1;
        wrap = x.inc && ((c & mask) == mask);
        ctrlw = w && s_c;
        m_irq = m_ovf && m_irqen;
        if (wrap) m_ovf = 1;
        else if (ctrlw && d[1]) m_ovf = 0;
        if (ctrlw) begin
            m_inh = d[0]; m_irqen = d[2]; m_frz = d[3];
        end else if (wrap && m_frz) begin
            m_inh = 1;
        end
        if (w && s_e) m_sel = d & 32'h0000_FFFF;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 0, 0, 0, 0, 0, 32'h0, 64'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("inc", 64'(inc), 64'(e.inc));
            chk("we", 64'(cwe), 64'(e.we));
            chk("weh", 64'(cwe_h), 64'(e.weh));
            chk("wdata", 64'(cwd), 64'(e.wd));
            chk("evt_sel", 64'(sel), 64'(e.sel));
            chk("ctrl", 64'(ctrl), 64'(e.ctrl));
            chk("irq", 64'(irq), 64'(e.irq));
            chk("weh_w32", 64'(cwe_h32), 64'(0));
            if (inc === 1'b1) inc_seen++;
        end
    end

    task automatic reset_check();
        @(posedge clk);
        #2;
        ev = '1; we = 1; lo = 1; hi = 1; sc = 0; se = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_inc", 64'(inc), 64'(0));
        chk("rst_we", 64'(cwe), 64'(0));
        chk("rst_weh", 64'(cwe_h), 64'(0));
        chk("rst_ctrl", 64'(ctrl), 64'(0));
        chk("rst_sel", 64'(sel), 64'(0));
        chk("rst_irq", 64'(irq), 64'(0));
        @(negedge clk);
        @(negedge clk);
        #2;
        ev = '0; we = 0; lo = 0; hi = 0;
        model_reset();
        rst_n = 1'b1;
    endtask

    localparam logic [63:0] FULL = 64'h0000_00FF_FFFF_FFFF;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        // Event selection
        step('0, 1, 0, 0, 1, 0, 32'h0005, 0);
        step('0, 1, 0, 0, 0, 1, 32'h0, 0);
        inc_seen = 0;
        for (int i = 0; i < 3; i++) step(16'h0004, 0, 0, 0, 0, 0, 0, 64'h10);
        step(16'h0002, 0, 0, 0, 0, 0, 0, 64'h10);
        idle(2);
        chk("inc_count", 64'(inc_seen), 64'd3);
        // Inhibit
        step('0, 1, 0, 0, 1, 0, 32'h0001, 0);
        step('0, 1, 0, 0, 0, 1, 32'h1, 0);
        step(16'h0001, 0, 0, 0, 0, 0, 0, 0);
        step(16'h0001, 0, 0, 0, 0, 0, 0, 0);
        // Write priority
        step('0, 1, 0, 0, 0, 1, 32'h0, 0);
        step(16'h0001, 1, 1, 0, 0, 0, 32'h1234, 0);
        step(16'h0001, 1, 1, 0, 0, 0, 32'h1234, 0);
        step('0, 1, 0, 1, 0, 0, 32'hABCD, 0);
        // Overflow with irq, then W1C
        step('0, 1, 0, 0, 0, 1, 32'h4, 0);
        step(16'h0001, 0, 0, 0, 0, 0, 0, FULL);
        step(16'h0001, 0, 0, 0, 0, 0, 0, FULL);
        idle(3);
        step('0, 1, 0, 0, 0, 1, 32'h6, 0);
        idle(3);
        // Freeze and wrap coincident with W1C
        step('0, 1, 0, 0, 0, 1, 32'hC, 0);
        step(16'h0001, 0, 0, 0, 0, 0, 0, FULL | 64'hFF00_0000_0000_0000);
        step(16'h0001, 0, 0, 0, 0, 0, 0, FULL);
        for (int i = 0; i < 4; i++) step(16'h0001, 0, 0, 0, 0, 0, 0, 64'h5);
        step('0, 1, 0, 0, 0, 1, 32'h4, 0);
        step(16'h0001, 0, 0, 0, 0, 0, 0, 0);
        step(16'h0001, 1, 0, 0, 0, 1, 32'h6, FULL);
        step(16'h0001, 1, 0, 0, 0, 1, 32'h6, FULL);
        idle(3);
        // Mid-count reset
        step(16'h0001, 0, 0, 0, 0, 0, 0, 0);
        reset_check();
        idle(2);
        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            logic [NE-1:0] re;
            logic [31:0]   rd;
            logic [63:0]   rc;
            bit            rw, rl, rh, rse, rsc;
            int unsigned   k;
            re = NE'($urandom);
            if ($urandom_range(1) == 0) re = re & NE'($urandom);
            rd = $urandom;
            rc = {$urandom, $urandom};
            if ($urandom_range(3) == 0) rc = rc | FULL;
            rw = 0; rl = 0; rh = 0; rse = 0; rsc = 0;
            if ($urandom_range(4) == 0) begin
                rw = 1;
                k = $urandom_range(4);
                case (k)
                    0: rl = 1;
                    1: rh = 1;
                    2: begin rl = 1; rh = 1; end
                    3: rse = 1;
                    default: begin rsc = 1; rd[0] = ($urandom_range(3) == 0); end
                endcase
            end
            step(re, rw, rl, rh, rse, rsc, rd, rc);
            if (i == 1500) reset_check();
        end
        idle(2);
        @(negedge clk);
        @(negedge clk);
        #3;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
